// File: rtl/fsm_button_tx.sv
// Push-button debouncer that toggles a registered on/off command on each confirmed press.
// Define FSM_BUTTON_TX_AUTO_OFF_EN to add a 16-bit auto-off timer that clears IN_cmd after TIMEOUT_CYCLES.
module fsm_button_tx #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Btn,
  output logic       IN_cmd,
  output logic       Press,
  output logic       Timeout,
  output logic [1:0] Estado_Salida
);

  localparam logic [1:0] ESPERA     = 2'b00;
  localparam logic [1:0] FILTRO_ON  = 2'b01;
  localparam logic [1:0] PRESIONADO = 2'b10;
  localparam logic [1:0] FILTRO_OFF = 2'b11;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("fsm_button_tx: DEBOUNCE_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("fsm_button_tx: TIMEOUT_CYCLES out of range 2..65535");
  end

  logic       sync1_r;
  logic       btn_s;
  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       toggle_s;
  logic       expire_s;
  logic       in_cmd_r;
  logic       press_r;
  logic       timeout_r;

  // Two-flop synchronizer for the raw button level
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync1_r <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync1_r <= Btn;
      btn_s   <= sync1_r;
    end
  end

  // Debounce next-state logic; toggle_s marks the single confirmed-press cycle
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    toggle_s    = 1'b0;
    case (state_r)
      ESPERA: begin
        if (btn_s) begin
          state_nxt_s = FILTRO_ON;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = ESPERA;
        end
      end
      FILTRO_ON: begin
        if (!btn_s) begin
          state_nxt_s = ESPERA;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = PRESIONADO;
          toggle_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      PRESIONADO: begin
        if (!btn_s) begin
          state_nxt_s = FILTRO_OFF;
          cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = PRESIONADO;
        end
      end
      FILTRO_OFF: begin
        if (btn_s) begin
          state_nxt_s = PRESIONADO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ESPERA;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ESPERA;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Debounce state and counter registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r <= ESPERA;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef FSM_BUTTON_TX_AUTO_OFF_EN
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timer_r;

  // A press confirmed in the expiry cycle wins, so the command is cleared only once
  assign expire_s = in_cmd_r && !toggle_s && (timer_r == TIMER_LAST);

  // On-time counter, running only while the command is asserted
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      timer_r <= 16'd0;
    end else if (!in_cmd_r || toggle_s || expire_s) begin
      timer_r <= 16'd0;
    end else begin
      timer_r <= timer_r + 16'd1;
    end
  end
`else
  assign expire_s = 1'b0;
`endif

  // Registered command level and event pulses
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      in_cmd_r  <= 1'b0;
      press_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if (toggle_s) begin
        in_cmd_r <= ~in_cmd_r;
      end else if (expire_s) begin
        in_cmd_r <= 1'b0;
      end else begin
        in_cmd_r <= in_cmd_r;
      end
      press_r   <= toggle_s;
      timeout_r <= expire_s;
    end
  end

  assign IN_cmd        = in_cmd_r;
  assign Press         = press_r;
  assign Timeout       = timeout_r;
  assign Estado_Salida = state_r;

endmodule

// File: tb/tb_fsm_button_tx.sv
// Bench for fsm_button_tx: directed scenarios plus random button traffic, every cycle
// compared against a run-length debounce model.
module tb_fsm_button_tx;

  localparam int DB = 4;
  localparam int TO = 10;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Btn = 1'b0;
  logic       IN_cmd;
  logic       Press;
  logic       Timeout;
  logic [1:0] Estado_Salida;

  always #5 Clk = ~Clk;

  fsm_button_tx #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Btn           (Btn),
    .IN_cmd        (IN_cmd),
    .Press         (Press),
    .Timeout       (Timeout),
    .Estado_Salida (Estado_Salida)
  );

  // Model: debounced level plus the length of the current run of opposite samples
  bit m_sync1, m_btns, m_lvl, m_in, m_press, m_tout;
  int m_run, m_age;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  edge_n, rise_edge, fall_edge, press_cnt, tout_cnt;
  bit  prev_in, seen_filter;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit b, input bit r);
    bit s;
    bit tog;
    if (!r) begin
      m_sync1 = 1'b0; m_btns = 1'b0; m_lvl = 1'b0; m_in = 1'b0;
      m_press = 1'b0; m_tout = 1'b0; m_run = 0; m_age = 0;
    end else begin
      s       = m_btns;
      m_btns  = m_sync1;
      m_sync1 = b;
      tog     = 1'b0;
      m_tout  = 1'b0;
      // A level change is accepted after DB+1 consecutive opposite samples
      if (s == m_lvl) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == DB + 1) begin
          m_lvl = s;
          m_run = 0;
          tog   = s;
        end
      end
      m_press = tog;
      if (tog) begin
        m_in  = ~m_in;
        m_age = 0;
      end else if (m_in) begin
        m_age++;
`ifdef FSM_BUTTON_TX_AUTO_OFF_EN
        if (m_age == TO) begin
          m_in   = 1'b0;
          m_tout = 1'b1;
          m_age  = 0;
        end
`endif
      end else begin
        m_age = 0;
      end
    end
  endtask

  task automatic arm();
    edge_n      = 0;
    rise_edge   = -1;
    fall_edge   = -1;
    press_cnt   = 0;
    tout_cnt    = 0;
    seen_filter = 1'b0;
    prev_in     = IN_cmd;
  endtask

  task automatic step(input bit b, input bit r);
    Btn     = b;
    Reset_n = r;
    @(posedge Clk);
    model_edge(b, r);
    edge_n++;
    @(negedge Clk);
    check("in_cmd",  16'(IN_cmd),  16'(m_in));
    check("press",   16'(Press),   16'(m_press));
    check("timeout", 16'(Timeout), 16'(m_tout));
    check("state",   16'(Estado_Salida), 16'({m_lvl, m_run != 0}));
    if (IN_cmd && !prev_in && rise_edge < 0) rise_edge = edge_n;
    if (!IN_cmd && prev_in && fall_edge < 0) fall_edge = edge_n;
    if (Press) press_cnt++;
    if (Timeout) tout_cnt++;
    if (Estado_Salida == 2'b01) seen_filter = 1'b1;
    prev_in = IN_cmd;
  endtask

  initial begin
    int len;
    bit b;
    @(negedge Clk);
    // Reset held, then released with the button idle
    repeat (2) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);

    // Clean press held 20 cycles: toggle at edge DB+3, one Press pulse
    arm();
    repeat (20) step(1'b1, 1'b1);
    check("press_latency", 16'(rise_edge), 16'(DB + 3));
    check("press_count_hold", 16'(press_cnt), 16'd1);
    repeat (20) step(1'b0, 1'b1);

    // Short 3-cycle blip is rejected
    step(1'b0, 1'b0);
    arm();
    repeat (3) step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    check("blip_seen_filter", 16'(seen_filter), 16'd1);
    check("blip_press_count", 16'(press_cnt), 16'd0);
    check("blip_no_rise", 16'(rise_edge), 16'hFFFF);

    // Two presses, the first with a 2-cycle low glitch while held
    arm();
    repeat (10) step(1'b1, 1'b1);
    repeat (2)  step(1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);
    check("two_press_count", 16'(press_cnt), 16'd2);

    // Reset pulsed at cnt=2 in the press filter, button kept high
    step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("abort_in_cmd", 16'(IN_cmd), 16'd0);
    arm();
    repeat (12) step(1'b1, 1'b1);
    check("repress_latency", 16'(rise_edge), 16'd7);
    repeat (20) step(1'b0, 1'b1);

    // Long hold: auto-off behaviour
    step(1'b0, 1'b0);
    arm();
    repeat (30) step(1'b1, 1'b1);
`ifdef FSM_BUTTON_TX_AUTO_OFF_EN
    check("auto_off_delay", 16'(fall_edge - rise_edge), 16'(TO));
    check("auto_off_pulses", 16'(tout_cnt), 16'd1);
`else
    check("hold_no_fall", 16'(fall_edge), 16'hFFFF);
    check("hold_no_timeout", 16'(tout_cnt), 16'd0);
`endif
    repeat (20) step(1'b0, 1'b1);

    // Random button traffic with occasional reset pulses
    for (int seg = 0; seg < 200; seg++) begin
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        step(b, ($urandom_range(0, 59) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
